clock_mode_ctrl: RTL and testbench
==================================

CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 Parameter IDLE_TIMEOUT, default 30, number of 1 Hz ticks without an advance button held before a set mode auto-exits to RUN; legal range 2..255.
REQ-002 Parameter BUZZ_SEC, default 60, maximum number of ticks the alarm sounds; legal range 1..255.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 tick  in  1  one-clk-wide 1 Hz enable pulse, synchronous to clk.
REQ-006 timeset, alarmset, minadv, hrsadv, alarmon  in  1 each  raw asynchronous button/switch levels, active-high.
REQ-007 szero  in  1  seconds counter at terminal count (59); mzero  in  1  minutes counter at terminal count (59).
REQ-008 alarm_match  in  1  combinational time==alarm (hours and minutes) compare.
REQ-009 sec_en, tmen, then, amen, ahen  out  1 each  count enables for the seconds, time-minutes, time-hours, alarm-minutes and alarm-hours counters.
REQ-010 sec_clr  out  1  one-cycle synchronous clear of the seconds counter.
REQ-011 disp_alarm  out  1  display mux select: 0 = time, 1 = alarm registers.
REQ-012 mode  out  2  current mode: 00 RUN, 01 TSET, 10 ASET.
REQ-013 buzz  out  1  alarm sounder drive.

Function
REQ-014 Each of the five raw inputs SHALL pass through a 2-flop synchronizer; rising-edge pulses of timeset and alarmset and of all buttons SHALL be derived from the synchronized level and a third flop.
REQ-015 The mode FSM SHALL have states RUN, TSET and ASET and SHALL be encoded exactly as on mode.
REQ-016 RUN -> TSET on timeset edge; RUN -> ASET on alarmset edge; both edges in the same cycle -> TSET.
REQ-017 TSET -> RUN on timeset edge; ASET -> RUN on alarmset edge; the other set edge SHALL be ignored in a set mode.
REQ-018 In TSET/ASET an 8-bit idle counter SHALL clear on mode entry and on any cycle with synchronized minadv or hrsadv high, increment on tick otherwise, and force -> RUN when it reaches IDLE_TIMEOUT on a tick.
REQ-019 Enables SHALL be combinational from registered state, synchronized levels, tick, szero and mzero, and asserted only in tick cycles.
REQ-020 RUN and ASET: sec_en = tick; tmen = tick & szero; then = tick & szero & mzero.
REQ-021 TSET: sec_en = 0 (seconds frozen); tmen = tick & minadv; then = tick & hrsadv; no minute-to-hour carry; both held -> both asserted.
REQ-022 ASET: amen = tick & minadv; ahen = tick & hrsadv; amen = ahen = 0 in RUN and TSET.
REQ-023 sec_clr SHALL pulse for exactly one cycle on the TSET -> RUN transition (button or timeout), registered, one cycle after the transition.
REQ-024 disp_alarm SHALL be 1 exactly while mode = ASET.
REQ-025 Alarm FSM states IDLE and RING; buzz = 1 exactly in RING.
REQ-026 IDLE -> RING when synchronized alarmon = 1, mode != ASET and alarm_match rises (registered previous value 0, current 1).
REQ-027 RING -> IDLE on the first of: synchronized alarmon = 0; BUZZ_SEC ticks counted in RING; any button rising edge (dismiss); entry to ASET.
REQ-028 A match rise occurring while in RING SHALL be ignored; a dismissed alarm SHALL not re-arm until alarm_match falls and rises again.

Reset
REQ-029 While rst = 1: mode = RUN, alarm FSM = IDLE, buzz = 0, sec_clr = 0, disp_alarm = 0, all counters and synchronizer/edge flops = 0; enables follow REQ-020 with tick.
REQ-030 Reset asserted mid-set or mid-ring SHALL abort immediately without emitting sec_clr; the first edge can be detected no earlier than 3 clk after rst deasserts.

Verification
REQ-031 RUN, szero = 1, mzero = 1, tick -> sec_en, tmen, then all 1 in that cycle; tick with szero = 0 -> only sec_en.
REQ-032 timeset pulse, hold minadv 5 ticks, pulse timeset -> mode 01, tmen pulses 5 times, sec_en 0 throughout, mode 00 then sec_clr one cycle.
REQ-033 alarmset pulse, no buttons for 30 ticks -> disp_alarm 1 then mode 00 on the 30th tick, amen/ahen never asserted.
REQ-034 alarmon = 1, alarm_match 0 -> 1 in RUN -> buzz 1 from next cycle; after 60 ticks buzz 0; match held high does not retrigger.
REQ-035 buzz ringing, press minadv -> buzz 0 within 4 clk; timeset and alarmset edges same cycle in RUN -> mode 01.
REQ-036 rst asserted while mode = TSET and buzz = 1 -> mode 00, buzz 0, sec_clr never pulses.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// Mode and alarm controller for a digital clock. It synchronizes the buttons,
// runs the RUN/TSET/ASET and IDLE/RING FSMs, and drives the counter enables.
module clock_mode_ctrl #(
  parameter int unsigned IDLE_TIMEOUT = 30,
  parameter int unsigned BUZZ_SEC     = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       timeset,
  input  logic       alarmset,
  input  logic       minadv,
  input  logic       hrsadv,
  input  logic       alarmon,
  input  logic       szero,
  input  logic       mzero,
  input  logic       alarm_match,
  output logic       sec_en,
  output logic       tmen,
  output logic       then,
  output logic       amen,
  output logic       ahen,
  output logic       sec_clr,
  output logic       disp_alarm,
  output logic [1:0] mode,
  output logic       buzz
);

  typedef enum logic [1:0] {RUN = 2'b00, TSET = 2'b01, ASET = 2'b10} mode_t;
  typedef enum logic {IDLE = 1'b0, RING = 1'b1} alarm_t;

  localparam logic [7:0] IDLE_LIM = 8'(IDLE_TIMEOUT);
  localparam logic [7:0] BUZZ_LIM = 8'(BUZZ_SEC);

  // Bit order: {alarmon, hrsadv, minadv, alarmset, timeset}
  logic [4:0] raw, s1, s2, s3, edges;
  logic       ts_e, as_e, btn_e, minadv_s, hrsadv_s, alarmon_s;

  mode_t      mode_q, mode_nxt;
  alarm_t     al_q, al_nxt;
  logic [7:0] idle_q, idle_nxt, bcnt_q, bcnt_nxt;
  logic       match_q, match_rise, sec_clr_q;

  assign raw        = {alarmon, hrsadv, minadv, alarmset, timeset};
  assign edges      = s2 & ~s3;
  assign ts_e       = edges[0];
  assign as_e       = edges[1];
  assign btn_e      = |edges[3:0];
  assign minadv_s   = s2[2];
  assign hrsadv_s   = s2[3];
  assign alarmon_s  = s2[4];
  assign match_rise = alarm_match & ~match_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      mode_q    <= RUN;
      al_q      <= IDLE;
      idle_q    <= '0;
      bcnt_q    <= '0;
      match_q   <= 1'b0;
      sec_clr_q <= 1'b0;
    end else begin
      s1        <= raw;
      s2        <= s1;
      s3        <= s2;
      mode_q    <= mode_nxt;
      al_q      <= al_nxt;
      idle_q    <= idle_nxt;
      bcnt_q    <= bcnt_nxt;
      match_q   <= alarm_match;
      sec_clr_q <= (mode_q == TSET) && (mode_nxt == RUN);
    end
  end

  // Idle counter is held at zero in RUN, so every set-mode entry starts fresh.
  always_comb begin
    mode_nxt = mode_q;
    idle_nxt = idle_q;
    unique case (mode_q)
      RUN: begin
        idle_nxt = '0;
        if (ts_e)      mode_nxt = TSET;
        else if (as_e) mode_nxt = ASET;
      end
      TSET:    if (ts_e) mode_nxt = RUN;
      ASET:    if (as_e) mode_nxt = RUN;
      default: mode_nxt = RUN;
    endcase
    if (mode_q != RUN) begin
      if (minadv_s || hrsadv_s) begin
        idle_nxt = '0;
      end else if (tick) begin
        if (idle_q + 8'd1 == IDLE_LIM) begin
          mode_nxt = RUN;
          idle_nxt = '0;
        end else begin
          idle_nxt = idle_q + 8'd1;
        end
      end
    end
  end

  always_comb begin
    al_nxt   = al_q;
    bcnt_nxt = bcnt_q;
    unique case (al_q)
      IDLE: begin
        bcnt_nxt = '0;
        if (alarmon_s && (mode_q != ASET) && match_rise) al_nxt = RING;
      end
      RING: begin
        if (!alarmon_s || btn_e || (mode_nxt == ASET)) begin
          al_nxt   = IDLE;
          bcnt_nxt = '0;
        end else if (tick) begin
          if (bcnt_q + 8'd1 == BUZZ_LIM) begin
            al_nxt   = IDLE;
            bcnt_nxt = '0;
          end else begin
            bcnt_nxt = bcnt_q + 8'd1;
          end
        end
      end
      default: al_nxt = IDLE;
    endcase
  end

  always_comb begin
    sec_en = 1'b0;
    tmen   = 1'b0;
    then   = 1'b0;
    amen   = 1'b0;
    ahen   = 1'b0;
    if (mode_q == TSET) begin
      tmen = tick & minadv_s;
      then = tick & hrsadv_s;
    end else begin
      sec_en = tick;
      tmen   = tick & szero;
      then   = tick & szero & mzero;
      if (mode_q == ASET) begin
        amen = tick & minadv_s;
        ahen = tick & hrsadv_s;
      end
    end
  end

  assign sec_clr    = sec_clr_q;
  assign disp_alarm = (mode_q == ASET);
  assign mode       = mode_q;
  assign buzz       = (al_q == RING);

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed self-checking bench for clock_mode_ctrl: vector table for the
// enable decode in each mode plus hand-written multi-cycle sequences.
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, timeset, alarmset, minadv, hrsadv, alarmon;
  logic       szero, mzero, alarm_match;
  logic       sec_en, tmen, then, amen, ahen, sec_clr, disp_alarm, buzz;
  logic [1:0] mode;

  int n_chk  = 0;
  int n_fail = 0;

  clock_mode_ctrl #(.IDLE_TIMEOUT(30), .BUZZ_SEC(60)) dut (
    .clk(clk), .rst(rst), .tick(tick), .timeset(timeset), .alarmset(alarmset),
    .minadv(minadv), .hrsadv(hrsadv), .alarmon(alarmon), .szero(szero),
    .mzero(mzero), .alarm_match(alarm_match), .sec_en(sec_en), .tmen(tmen),
    .then(then), .amen(amen), .ahen(ahen), .sec_clr(sec_clr),
    .disp_alarm(disp_alarm), .mode(mode), .buzz(buzz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] md;
    logic       tk, sz, mz, mn, hr;
    logic [4:0] exp;  // {sec_en, tmen, then, amen, ahen}
  } vec_t;

  vec_t vecs[15];
  logic [1:0] cur;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ts();
    timeset = 1'b1;
    repeat (4) cyc();
    timeset = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic pulse_as();
    alarmset = 1'b1;
    repeat (4) cyc();
    alarmset = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic go_mode(input logic [1:0] target);
    minadv = 1'b0;
    hrsadv = 1'b0;
    tick   = 1'b0;
    repeat (4) cyc();
    if (cur == 2'd1) pulse_ts();
    if (cur == 2'd2) pulse_as();
    if (target == 2'd1) pulse_ts();
    if (target == 2'd2) pulse_as();
    cur = target;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; timeset = 1'b0; alarmset = 1'b0; minadv = 1'b0;
    hrsadv = 1'b0; alarmon = 1'b0; szero = 1'b0; mzero = 1'b0;
    alarm_match = 1'b0;
    cur = 2'd0;

    //            md    tk    sz    mz    mn    hr    exp
    vecs[0]  = '{2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b11100};
    vecs[1]  = '{2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b10000};
    vecs[2]  = '{2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000};
    vecs[3]  = '{2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
    vecs[4]  = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'b10000};
    vecs[5]  = '{2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
    vecs[6]  = '{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b01000};
    vecs[7]  = '{2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00100};
    vecs[8]  = '{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'b01100};
    vecs[9]  = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000};
    vecs[10] = '{2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000};
    vecs[11] = '{2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b11100};
    vecs[12] = '{2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10010};
    vecs[13] = '{2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b10001};
    vecs[14] = '{2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000};

    // Reset state, with RUN-mode enables still following tick
    repeat (2) cyc();
    tick = 1'b1; szero = 1'b1; mzero = 1'b1;
    #1;
    chk("rst_mode", int'(mode), 0);
    chk("rst_buzz", int'(buzz), 0);
    chk("rst_secclr", int'(sec_clr), 0);
    chk("rst_disp", int'(disp_alarm), 0);
    chk("rst_enables", int'({sec_en, tmen, then, amen, ahen}), int'(5'b11100));
    tick = 1'b0;
    cyc();
    rst = 1'b0;
    repeat (2) cyc();

    // Enable decode table, mode by mode
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].md != cur) go_mode(vecs[i].md);
      chk($sformatf("vec%0d_mode", i), int'(mode), int'(vecs[i].md));
      minadv = vecs[i].mn; hrsadv = vecs[i].hr;
      szero  = vecs[i].sz; mzero  = vecs[i].mz;
      tick   = 1'b0;
      repeat (4) cyc();
      tick = vecs[i].tk;
      #1;
      chk($sformatf("vec%0d_en", i), int'({sec_en, tmen, then, amen, ahen}),
          int'(vecs[i].exp));
      chk($sformatf("vec%0d_disp", i), int'(disp_alarm), int'(vecs[i].md == 2'd2));
      cyc();
      tick = 1'b0;
    end
    go_mode(2'd0);
    szero = 1'b0; mzero = 1'b0;

    // Time set: hold minadv for 5 ticks, exit by button, one sec_clr
    timeset = 1'b1;
    for (int k = 0; k < 8 && mode != 2'd1; k++) cyc();
    chk("tset_enter", int'(mode), 1);
    timeset = 1'b0;
    minadv = 1'b1;
    repeat (4) cyc();
    for (int k = 0; k < 5; k++) begin
      tick = 1'b1;
      #1;
      chk($sformatf("tset_tmen%0d", k), int'(tmen), 1);
      chk($sformatf("tset_secen%0d", k), int'(sec_en), 0);
      cyc();
      tick = 1'b0;
      cyc();
    end
    minadv = 1'b0;
    repeat (4) cyc();
    chk("tset_secclr_before", int'(sec_clr), 0);
    timeset = 1'b1;
    for (int k = 0; k < 8 && mode != 2'd0; k++) cyc();
    chk("tset_exit", int'(mode), 0);
    chk("tset_secclr_pulse", int'(sec_clr), 1);
    cyc();
    chk("tset_secclr_end", int'(sec_clr), 0);
    timeset = 1'b0;
    repeat (4) cyc();

    // Alarm set with no buttons: timeout on the 30th tick
    pulse_as();
    chk("aset_mode", int'(mode), 2);
    chk("aset_disp", int'(disp_alarm), 1);
    for (int k = 1; k <= 30; k++) begin
      tick = 1'b1;
      #1;
      chk($sformatf("aset_aen%0d", k), int'({amen, ahen}), 0);
      cyc();
      tick = 1'b0;
      if (k == 29) chk("aset_before_to", int'(mode), 2);
      if (k == 30) begin
        chk("aset_timeout", int'(mode), 0);
        chk("aset_disp_off", int'(disp_alarm), 0);
      end
      cyc();
    end

    // Alarm rings for 60 ticks, held match does not retrigger
    alarmon = 1'b1;
    repeat (4) cyc();
    alarm_match = 1'b1;
    #1;
    chk("ring_not_yet", int'(buzz), 0);
    cyc();
    chk("ring_start", int'(buzz), 1);
    for (int k = 1; k <= 65; k++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      if (k == 59) chk("ring_tick59", int'(buzz), 1);
      if (k == 60) chk("ring_tick60", int'(buzz), 0);
      if (k == 65) chk("ring_no_retrigger", int'(buzz), 0);
      cyc();
    end

    // Dismiss by minadv within 4 clk
    alarm_match = 1'b0;
    cyc();
    alarm_match = 1'b1;
    cyc();
    chk("dismiss_ring", int'(buzz), 1);
    minadv = 1'b1;
    for (int k = 0; k < 4 && buzz; k++) cyc();
    chk("dismiss_buzz", int'(buzz), 0);
    minadv = 1'b0;
    repeat (4) cyc();

    // Simultaneous timeset/alarmset edges in RUN select TSET
    timeset = 1'b1; alarmset = 1'b1;
    repeat (4) cyc();
    chk("both_edges", int'(mode), 1);
    timeset = 1'b0; alarmset = 1'b0;
    repeat (4) cyc();
    cur = 2'd1;

    // Ring while in TSET, then reset aborts both without sec_clr
    alarm_match = 1'b0;
    cyc();
    alarm_match = 1'b1;
    cyc();
    chk("rst_pre_buzz", int'(buzz), 1);
    chk("rst_pre_mode", int'(mode), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_mode", int'(mode), 0);
    chk("rst_mid_buzz", int'(buzz), 0);
    chk("rst_mid_secclr", int'(sec_clr), 0);
    cyc();
    rst = 1'b0;
    begin
      int clr_seen = 0;
      for (int k = 0; k < 10; k++) begin
        cyc();
        if (sec_clr) clr_seen++;
      end
      chk("rst_no_secclr", clr_seen, 0);
    end
    chk("rst_post_buzz", int'(buzz), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
